// File: rtl/rtc_pkg.sv
// rtc_pkg: shared limits, BCD digit types and display helpers for rtc_timekeeper
package rtc_pkg;
    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;

    typedef logic [1:0] bcd2_t;
    typedef logic [2:0] bcd3_t;
    typedef logic [3:0] bcd4_t;

    typedef struct packed {
        bcd2_t tens;
        bcd4_t ones;
    } hr_bcd_t;

    typedef struct packed {
        bcd3_t tens;
        bcd4_t ones;
    } ms_bcd_t;

    function automatic logic [4:0] hour_12h(input logic [4:0] hr);
        return (hr == 5'd0) ? 5'd12 : (hr > 5'd12) ? hr - 5'd12 : hr;
    endfunction

    function automatic hr_bcd_t hr_split(input logic [4:0] h);
        hr_bcd_t p;
        p.tens = (h >= 5'd20) ? 2'd2 : (h >= 5'd10) ? 2'd1 : 2'd0;
        p.ones = 4'((h >= 5'd20) ? h - 5'd20 : (h >= 5'd10) ? h - 5'd10 : h);
        return p;
    endfunction

    function automatic ms_bcd_t ms_split(input logic [5:0] v);
        ms_bcd_t p;
        logic [5:0] r;
        p.tens = '0;
        r = v;
        for (int i = 0; i < 5; i++)
            if (r >= 6'd10) begin
                r = r - 6'd10;
                p.tens = p.tens + 3'd1;
            end
        p.ones = 4'(r);
        return p;
    endfunction
endpackage

// File: rtl/rtc_button.sv
// rtc_button: synchroniser, debouncer and hold/auto-repeat set-pulse generator for one button
module rtc_button #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 6_250_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic pulse_o
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW = $clog2((HOLD_CYC > REPEAT_CYC ? HOLD_CYC : REPEAT_CYC) + 1);

    logic s1, s2, level, armed, first, cur;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;

    // until a debounced release is seen after reset, the button is treated as pressed
    assign cur = armed ? level : 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            level   <= 1'b0;
            armed   <= 1'b0;
            first   <= 1'b0;
            dcnt    <= '0;
            rcnt    <= '0;
            pulse_o <= 1'b0;
        end else begin
            s1      <= button_i;
            s2      <= s1;
            pulse_o <= 1'b0;
            if (s2 != cur) begin
                dcnt <= dcnt + DW'(1);
                if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
                    dcnt    <= '0;
                    level   <= s2;
                    armed   <= 1'b1;
                    pulse_o <= s2;
                    rcnt    <= '0;
                    first   <= 1'b1;
                end
            end else begin
                dcnt <= '0;
                if (level) begin
                    rcnt <= rcnt + RW'(1);
                    if (rcnt == (first ? RW'(HOLD_CYC - 1) : RW'(REPEAT_CYC - 1))) begin
                        pulse_o <= 1'b1;
                        rcnt    <= '0;
                        first   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: HH:MM:SS real-time clock with button setting and 12/24-hour BCD display
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 6_250_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       button_hr_i,
    input  logic       button_min_i,
    input  logic       mode_12h_i,
    output logic [1:0] hr_tens_o,
    output logic [3:0] hr_ones_o,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [2:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       pm_o,
    output logic       sec_tick_o
);
    localparam int PW = $clog2(CLK_HZ);

    logic [PW-1:0] presc;
    logic [4:0]    hours, hr_disp;
    logic [5:0]    minutes, seconds;
    logic          tick, set_hr, set_min;

    rtc_button #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) u_btn_hr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .button_i(button_hr_i),
        .pulse_o (set_hr)
    );

    rtc_button #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) u_btn_min (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .button_i(button_min_i),
        .pulse_o (set_min)
    );

    assign tick = presc == PW'(CLK_HZ - 1);

    // a set pulse takes priority over the tick's advance; both set pulses may apply together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc      <= '0;
            hours      <= '0;
            minutes    <= '0;
            seconds    <= '0;
            sec_tick_o <= 1'b0;
        end else begin
            sec_tick_o <= tick;
            presc      <= (tick || set_min) ? '0 : presc + PW'(1);
            if (set_hr || set_min) begin
                if (set_hr)
                    hours <= (hours == HR_MAX) ? '0 : hours + 5'd1;
                if (set_min) begin
                    minutes <= (minutes == MIN_MAX) ? '0 : minutes + 6'd1;
                    seconds <= '0;
                end
            end else if (tick) begin
                seconds <= (seconds == SEC_MAX) ? '0 : seconds + 6'd1;
                if (seconds == SEC_MAX) begin
                    minutes <= (minutes == MIN_MAX) ? '0 : minutes + 6'd1;
                    if (minutes == MIN_MAX)
                        hours <= (hours == HR_MAX) ? '0 : hours + 5'd1;
                end
            end
        end
    end

    assign hr_disp                  = mode_12h_i ? hour_12h(hours) : hours;
    assign pm_o                     = mode_12h_i && (hours >= 5'd12);
    assign {hr_tens_o, hr_ones_o}   = hr_split(hr_disp);
    assign {min_tens_o, min_ones_o} = ms_split(minutes);
    assign {sec_tens_o, sec_ones_o} = ms_split(seconds);
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed scoreboard bench for rtc_timekeeper with small sim parameters
module tb_rtc_timekeeper;
    logic       clk_i = 1'b0;
    logic       rst_i, button_hr_i, button_min_i, mode_12h_i;
    logic [1:0] hr_tens_o;
    logic [3:0] hr_ones_o, min_ones_o, sec_ones_o;
    logic [2:0] min_tens_o, sec_tens_o;
    logic       pm_o, sec_tick_o;
    int         errors = 0;
    int         checks = 0;
    int         ticks;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    rtc_timekeeper #(
        .CLK_HZ(10), .DEBOUNCE_CYC(3), .HOLD_CYC(20), .REPEAT_CYC(5)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .button_hr_i(button_hr_i),
        .button_min_i(button_min_i), .mode_12h_i(mode_12h_i),
        .hr_tens_o(hr_tens_o), .hr_ones_o(hr_ones_o),
        .min_tens_o(min_tens_o), .min_ones_o(min_ones_o),
        .sec_tens_o(sec_tens_o), .sec_ones_o(sec_ones_o),
        .pm_o(pm_o), .sec_tick_o(sec_tick_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] t(input int h, input int m, input int s, input int pm);
        return 32'({4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(pm)});
    endfunction

    function automatic logic [31:0] th(input int h, input int pm);
        return 32'({4'(h / 10), 4'(h % 10), 4'(pm)});
    endfunction

    function automatic logic [31:0] disp();
        return 32'({2'b0, hr_tens_o, hr_ones_o, 1'b0, min_tens_o, min_ones_o,
                    1'b0, sec_tens_o, sec_ones_o, 3'b0, pm_o});
    endfunction

    function automatic logic [31:0] hdisp();
        return 32'({2'b0, hr_tens_o, hr_ones_o, 3'b0, pm_o});
    endfunction

    function automatic int hr_now();
        return int'(hr_tens_o) * 10 + int'(hr_ones_o);
    endfunction

    function automatic int min_now();
        return int'(min_tens_o) * 10 + int'(min_ones_o);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] got);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got=0x%0h", got);
        end else begin
            e = sb.pop_front();
            assert (got === e.val)
            else begin
                errors++;
                $error("FAIL %s got=0x%0h exp=0x%0h", e.tag, got, e.val);
            end
        end
    endtask

    // pulse lands 5 cycles after the edge, counters update on the 6th
    task automatic press(input logic h, input logic m);
        button_hr_i  = h;
        button_min_i = m;
        cyc(4);
        button_hr_i  = 1'b0;
        button_min_i = 1'b0;
        cyc(6);
    endtask

    initial begin
        rst_i = 1'b1; button_hr_i = 1'b0; button_min_i = 1'b0; mode_12h_i = 1'b0;
        cyc(3);
        exp_push("reset_24h", t(0, 0, 0, 0));  check(disp());
        exp_push("reset_tick", 0);             check(32'(sec_tick_o));
        mode_12h_i = 1'b1; #1;
        exp_push("reset_12h", t(12, 0, 0, 0)); check(disp());
        mode_12h_i = 1'b0;
        rst_i = 1'b0;

        ticks = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            ticks += int'(sec_tick_o);
        end
        exp_push("tick_count", 60);            check(ticks);
        exp_push("one_minute", t(0, 1, 0, 0)); check(disp());

        for (int i = 0; i < 23; i++) press(1'b1, 1'b0);
        exp_push("hr_preload", 23);            check(hr_now());
        for (int i = 0; i < 58; i++) press(1'b0, 1'b1);
        exp_push("min_preload", t(23, 59, 0, 0)); check(disp());
        cyc(576);
        exp_push("at_58", t(23, 59, 58, 0));   check(disp());
        cyc(10);
        exp_push("at_59", t(23, 59, 59, 0));   check(disp());
        exp_push("at_59_tick", 1);             check(32'(sec_tick_o));
        cyc(9);
        exp_push("hold_59", t(23, 59, 59, 0)); check(disp());
        cyc(1);
        exp_push("rollover", t(0, 0, 0, 0));   check(disp());
        exp_push("rollover_tick", 1);          check(32'(sec_tick_o));

        button_hr_i = 1'b1; cyc(2); button_hr_i = 1'b0; cyc(12);
        exp_push("glitch_ignored", 0);         check(hr_now());
        button_hr_i = 1'b1; cyc(4); button_hr_i = 1'b0; cyc(1);
        exp_push("hr_pre_update", 0);          check(hr_now());
        cyc(1);
        exp_push("hr_single_inc", 1);          check(hr_now());
        cyc(20);
        exp_push("hr_no_repeat", 1);           check(hr_now());

        button_min_i = 1'b1;
        exp_push("hold_p1", t(1, 1, 0, 0));
        exp_push("hold_p2_on_tick", t(1, 2, 0, 0));
        exp_push("hold_p2_tick", 1);
        exp_push("hold_p3", t(1, 3, 0, 0));
        exp_push("hold_p4", t(1, 4, 0, 0));
        cyc(6);  check(disp());
        cyc(20); check(disp()); check(32'(sec_tick_o));
        cyc(5);  check(disp());
        cyc(5);  check(disp());
        button_min_i = 1'b0;
        cyc(24);
        exp_push("hold_stop", 4);              check(min_now());

        press(1'b1, 1'b1);
        exp_push("both_set", t(2, 5, 0, 0));   check(disp());

        button_hr_i = 1'b1;
        cyc(10);
        exp_push("hold_before_reset", 3);      check(hr_now());
        rst_i = 1'b1;
        cyc(1);
        exp_push("mid_reset", t(0, 0, 0, 0));  check(disp());
        exp_push("mid_reset_tick", 0);         check(32'(sec_tick_o));
        rst_i = 1'b0;
        cyc(49);
        exp_push("held_through_reset", t(0, 0, 4, 0)); check(disp());
        mode_12h_i = 1'b1; #1;
        exp_push("h0_12h", t(12, 0, 4, 0));    check(disp());
        mode_12h_i = 1'b0;
        button_hr_i = 1'b0;
        cyc(10);
        press(1'b1, 1'b0);
        exp_push("rearm_press", 1);            check(hr_now());

        for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
        mode_12h_i = 1'b1; #1;
        exp_push("h12_12h", th(12, 1));        check(hdisp());
        press(1'b1, 1'b0);
        exp_push("h13_12h", th(1, 1));         check(hdisp());
        mode_12h_i = 1'b0; #1;
        exp_push("h13_24h", th(13, 0));        check(hdisp());
        mode_12h_i = 1'b1; #1;
        exp_push("h13_back_12h", th(1, 1));    check(hdisp());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised real-time clock core: counts hours, minutes and seconds from a single system clock using an internal prescaler. Two push-buttons set hours and minutes, with debounce and hold-to-auto-repeat. A run-time 12/24-hour display mode is supported. Outputs are per-digit BCD plus PM flag and a seconds tick, and drive the display multiplexer directly.

## Interface
- CLK_HZ, 50_000_000: system clock cycles per second; prescaler modulus (≥2).
- DEBOUNCE_CYC, 500_000: consecutive stable synchronised samples required to accept a button level change (≥1).
- HOLD_CYC, 25_000_000: cycles a button must stay pressed after acceptance before auto-repeat starts (≥1).
- REPEAT_CYC, 6_250_000: cycles between auto-repeat increments (≥1).
- clk_i  in  1  system clock; single clock domain, everything on posedge.
- rst_i  in  1  reset; synchronous and active-high.
- button_hr_i  in  1  hour-set button, asynchronous, active-high.
- button_min_i  in  1  minute-set button, asynchronous, active-high.
- mode_12h_i  in  1  1 = 12-hour display, 0 = 24-hour; affects display only.
- hr_tens_o  out  2  hour tens digit, BCD.
- hr_ones_o  out  4  hour ones digit, BCD.
- min_tens_o  out  3  minute tens digit, BCD.
- min_ones_o  out  4  minute ones digit, BCD.
- sec_tens_o  out  3  second tens digit, BCD.
- sec_ones_o  out  4  second ones digit, BCD.
- pm_o  out  1  1 when mode_12h_i=1 and hour ≥12; 0 in 24-hour mode.
- sec_tick_o  out  1  one-cycle pulse on each prescaler wrap.

## Operation
- State: binary hr 0..23, min 0..59, sec 0..59, prescaler 0..CLK_HZ-1; all reset to 0.
- Prescaler increments every cycle, wraps CLK_HZ-1→0. The wrap cycle asserts tick.
- Tick with no set pulse: sec+1. At 59: sec→0, min+1. At min 59 as well: min→0, hr+1. At hr 23 as well: hr→0 (full rollover 23:59:59→00:00:00 in one cycle).
- Each button passes through a 2-FF synchroniser, then the debouncer. The debounced level flips only after DEBOUNCE_CYC consecutive samples differing from the current level.
- Debounced rising edge produces one set pulse. While still pressed, a pulse follows HOLD_CYC cycles after the edge, then every REPEAT_CYC cycles. Release stops repeat immediately. Release is itself debounced.
- Hour set pulse: hr+1, 23→0; min and sec untouched.
- Minute set pulse: min+1, 59→0 with no hour carry. Also clears sec and prescaler to 0.
- Set pulse coinciding with tick: the tick's timekeeping advance is dropped. sec_tick_o is still asserted. Prescaler still wraps unless cleared by a minute set.
- Both set pulses in the same cycle: both applied.
- Display mapping, 24h: digits of hr directly.
- Display mapping, 12h: hr 0→12 (pm_o=0); 1..11→same (pm_o=0); 12→12 (pm_o=1); 13..23→hr-12 (pm_o=1).
- Digit split uses compare/subtract, no divider. Tens widths are the exact ones listed.

## Timing
- BCD digits and pm_o are combinational from the state registers and mode_12h_i. They change in the same cycle the registers update.
- sec_tick_o is registered: high for exactly the cycle after prescaler = CLK_HZ-1, i.e. coincident with the sec update becoming visible.
- Button latency: 2 synchroniser cycles + DEBOUNCE_CYC cycles to the set pulse, then 1 cycle to the counter update.
- Reset mid-operation: next cycle all state is 0, debouncers are released, and repeat timers are cleared. A button held through reset must be seen released-then-pressed (debounced) before any pulse.
- Reset outputs: 24h mode shows 00:00:00 with pm_o=0. 12h mode shows hr_tens=1, hr_ones=2, rest 0, pm_o=0. sec_tick_o=0.

## Structure
- Package rtc_pkg holds:
  - constants HR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - BCD digit typedefs;
  - the 12h mapping and binary-to-BCD-split functions.
- Sub-module rtc_button (synchroniser + debouncer + hold/repeat pulse generator), parameters DEBOUNCE_CYC/HOLD_CYC/REPEAT_CYC. Instantiated twice.
- Top holds the prescaler, counters, priority logic and display mapping.

## Test plan
Sim parameters: CLK_HZ=10, DEBOUNCE_CYC=3, HOLD_CYC=20, REPEAT_CYC=5.
- Reset, mode_12h_i=0, run 600 cycles -> 60 sec_tick_o pulses; display 00:01:00.
- Preload 23:59:58 via button presses, run 20 cycles -> 23:59:59 then 00:00:00 on the same cycle min/hr roll.
- Button_hr glitches 2 cycles high -> no change. Press 4 cycles high, release -> hr increments exactly once, 5 cycles after the rising edge.
- Hold button_min 40 cycles -> pulses at edge+5, +25, +30, +35 (4 increments). sec=0 after each pulse.
- mode_12h_i=1 with hr=0, 12, 13 -> 12 pm_o=0, 12 pm_o=1, 01 pm_o=1. Toggling mode leaves counters unchanged.
- Minute set pulse on the tick cycle -> sec=0, no lost/extra minute. Reset asserted mid-hold -> all zero, no pulse until re-press.
